// File: rtl/vnu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// vnu_ctrl_pkg
// Shared definitions for the VNU write/update controller:
//   - vnu_state_e    : controller state encoding
//   - DEF_*          : default parameter values for the controller
//   - wr_lat_cnt_w() : width of the write-latency down-counter
// ---------------------------------------------------------------------------
package vnu_ctrl_pkg;

  localparam int unsigned DEF_CH_NUM = 4;
  localparam int unsigned DEF_WR_LAT = 2;
  localparam int unsigned DEF_ITER_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_LOAD,
    ST_PIPE_LOAD,
    ST_WR_WAIT,
    ST_WR_PULSE,
    ST_DONE
  } vnu_state_e;

  // The wait counter is loaded with WR_LAT-2 and counts down to zero, so it
  // only has to hold values up to WR_LAT-2. Never narrower than one bit.
  function automatic int unsigned wr_lat_cnt_w(input int unsigned wr_lat);
    return (wr_lat < 3) ? 1 : $clog2(wr_lat - 1);
  endfunction

endpackage

// File: rtl/vnu_finish_collector.sv
// ---------------------------------------------------------------------------
// vnu_finish_collector
// Sticky per-channel read-finish mask with an all-channels-done compare.
// Ports:
//   read_clk, rstn : clock, async active-low reset
//   clear          : empty the mask (asserted on entry to a load phase)
//   collect        : OR the enabled finish bits into the mask this cycle
//   ch_en          : latched channel enable mask
//   finish         : registered per-channel finish strobes
//   all_done       : every enabled channel has finished (disabled = done)
// ---------------------------------------------------------------------------
module vnu_finish_collector
  import vnu_ctrl_pkg::*;
#(
  parameter int unsigned CH_NUM = DEF_CH_NUM
) (
  input  logic              read_clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              collect,
  input  logic [CH_NUM-1:0] ch_en,
  input  logic [CH_NUM-1:0] finish,
  output logic              all_done
);

  logic [CH_NUM-1:0] mask;

  // Finish bits of disabled channels are dropped so the mask only ever
  // reflects channels that actually take part in this iteration.
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      mask <= '0;
    end else if (clear) begin
      mask <= '0;
    end else if (collect) begin
      mask <= mask | (finish & ch_en);
    end
  end

  // An empty enable mask reads as done immediately.
  assign all_done = &(mask | ~ch_en);

endmodule

// File: rtl/vnu_wr_update_ctrl.sv
// ---------------------------------------------------------------------------
// vnu_wr_update_ctrl
// Sequences one decoder iteration: waits for an update request, runs an
// initial-load or pipeline-load phase until every enabled VNU channel has
// reported read-finish, waits WR_LAT cycles, pulses the channel writes and
// counts the iteration. The frame ends on the iteration limit or early stop.
// Ports:
//   read_clk, rstn      : clock, async active-low reset
//   iter_update_i       : iteration-update request
//   vnu_init_load_en_i  : request is the first (initial-load) iteration
//   vnu_rd_finish_i     : per-channel read-finish strobes
//   ch_en_i             : channel enable mask, latched at load entry
//   max_iter_i          : iterations per frame (0 behaves as 1)
//   early_stop_i        : syndrome-pass stop request
//   init_load_o         : initial-load phase active
//   pipe_load_o         : pipeline-load phase active
//   vnu_wr_o            : one-cycle write pulse per enabled channel
//   iter_cnt_o          : completed iterations in current frame
//   decode_done_o       : frame finished (level)
//   overrun_o           : one-cycle pulse, update request discarded
// ---------------------------------------------------------------------------
module vnu_wr_update_ctrl
  import vnu_ctrl_pkg::*;
#(
  parameter int unsigned CH_NUM = DEF_CH_NUM,
  parameter int unsigned WR_LAT = DEF_WR_LAT,
  parameter int unsigned ITER_W = DEF_ITER_W
) (
  input  logic              read_clk,
  input  logic              rstn,
  input  logic              iter_update_i,
  input  logic              vnu_init_load_en_i,
  input  logic [CH_NUM-1:0] vnu_rd_finish_i,
  input  logic [CH_NUM-1:0] ch_en_i,
  input  logic [ITER_W-1:0] max_iter_i,
  input  logic              early_stop_i,
  output logic              init_load_o,
  output logic              pipe_load_o,
  output logic [CH_NUM-1:0] vnu_wr_o,
  output logic [ITER_W-1:0] iter_cnt_o,
  output logic              decode_done_o,
  output logic              overrun_o
);

  localparam int unsigned CNT_W     = wr_lat_cnt_w(WR_LAT);
  localparam int unsigned WAIT_LOAD = (WR_LAT > 1) ? WR_LAT - 2 : 0;

  vnu_state_e        state;
  logic              upd_q;
  logic              init_en_q;
  logic [CH_NUM-1:0] fin_q;
  logic              stop_q;
  logic [CH_NUM-1:0] ch_en_lat;
  logic [ITER_W-1:0] iter_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic              stop_flag;
  logic              all_done;
  logic              start;
  logic              load_state;
  logic              quiet_state;
  logic [ITER_W-1:0] iter_next;
  logic [ITER_W-1:0] max_eff;

  // Control inputs pass through one register stage before the FSM sees them.
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      upd_q     <= 1'b0;
      init_en_q <= 1'b0;
      fin_q     <= '0;
      stop_q    <= 1'b0;
    end else begin
      upd_q     <= iter_update_i;
      init_en_q <= vnu_init_load_en_i;
      fin_q     <= vnu_rd_finish_i;
      stop_q    <= early_stop_i;
    end
  end

  assign quiet_state = (state == ST_IDLE) || (state == ST_DONE);
  assign load_state  = (state == ST_INIT_LOAD) || (state == ST_PIPE_LOAD);
  // DONE only accepts a request that opens a new frame.
  assign start       = upd_q && ((state == ST_IDLE) || ((state == ST_DONE) && init_en_q));
  assign iter_next   = (iter_cnt == '1) ? iter_cnt : iter_cnt + ITER_W'(1);
  assign max_eff     = (max_iter_i == '0) ? ITER_W'(1) : max_iter_i;
  assign iter_cnt_o  = iter_cnt;

  vnu_finish_collector #(
    .CH_NUM (CH_NUM)
  ) u_collector (
    .read_clk (read_clk),
    .rstn     (rstn),
    .clear    (start),
    .collect  (load_state),
    .ch_en    (ch_en_lat),
    .finish   (fin_q),
    .all_done (all_done)
  );

  // Main sequencer. Outputs are decoded from the current state and registered,
  // so they follow the state register by one cycle. An early stop seen in the
  // write-pulse cycle itself still counts for that iteration.
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      ch_en_lat     <= '0;
      iter_cnt      <= '0;
      wr_cnt        <= '0;
      stop_flag     <= 1'b0;
      init_load_o   <= 1'b0;
      pipe_load_o   <= 1'b0;
      vnu_wr_o      <= '0;
      decode_done_o <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      init_load_o   <= (state == ST_INIT_LOAD);
      pipe_load_o   <= (state == ST_PIPE_LOAD);
      vnu_wr_o      <= (state == ST_WR_PULSE) ? ch_en_lat : '0;
      decode_done_o <= (state == ST_DONE);
      overrun_o     <= upd_q && !start;

      if (!quiet_state && stop_q) begin
        stop_flag <= 1'b1;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            ch_en_lat <= ch_en_i;
            if (init_en_q) begin
              state    <= ST_INIT_LOAD;
              iter_cnt <= '0;
            end else begin
              state <= ST_PIPE_LOAD;
            end
          end
        end
        ST_INIT_LOAD, ST_PIPE_LOAD: begin
          if (all_done) begin
            if (WR_LAT > 1) begin
              state  <= ST_WR_WAIT;
              wr_cnt <= CNT_W'(WAIT_LOAD);
            end else begin
              state <= ST_WR_PULSE;
            end
          end
        end
        ST_WR_WAIT: begin
          if (wr_cnt == '0) begin
            state <= ST_WR_PULSE;
          end else begin
            wr_cnt <= wr_cnt - CNT_W'(1);
          end
        end
        ST_WR_PULSE: begin
          iter_cnt  <= iter_next;
          stop_flag <= 1'b0;
          if ((iter_next >= max_eff) || stop_flag || stop_q) begin
            state <= ST_DONE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vnu_wr_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vnu_wr_update_ctrl
// Self-checking bench for vnu_wr_update_ctrl (CH_NUM=4, WR_LAT=2, ITER_W=5).
// Hand-written timing sequences, a table of iteration records, and random
// frames checked against a transaction-level model of the iteration rules.
// ---------------------------------------------------------------------------
module tb_vnu_wr_update_ctrl;

  localparam int CH = 4;
  localparam int IW = 5;

  logic          read_clk = 1'b0;
  logic          rstn;
  logic          iter_update_i;
  logic          vnu_init_load_en_i;
  logic [CH-1:0] vnu_rd_finish_i;
  logic [CH-1:0] ch_en_i;
  logic [IW-1:0] max_iter_i;
  logic          early_stop_i;
  logic          init_load_o;
  logic          pipe_load_o;
  logic [CH-1:0] vnu_wr_o;
  logic [IW-1:0] iter_cnt_o;
  logic          decode_done_o;
  logic          overrun_o;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int ov_cnt   = 0;

  typedef struct {
    logic          init;
    logic [CH-1:0] en;
    logic [IW-1:0] max_iter;
    logic [CH-1:0] fin;
    logic          stop;
    logic [CH-1:0] exp_wr;
    int            exp_pulses;
    logic [IW-1:0] exp_iter;
    logic          exp_done;
  } vec_t;

  vec_t vecs [9];

  vnu_wr_update_ctrl #(
    .CH_NUM (CH),
    .WR_LAT (2),
    .ITER_W (IW)
  ) dut (
    .read_clk           (read_clk),
    .rstn               (rstn),
    .iter_update_i      (iter_update_i),
    .vnu_init_load_en_i (vnu_init_load_en_i),
    .vnu_rd_finish_i    (vnu_rd_finish_i),
    .ch_en_i            (ch_en_i),
    .max_iter_i         (max_iter_i),
    .early_stop_i       (early_stop_i),
    .init_load_o        (init_load_o),
    .pipe_load_o        (pipe_load_o),
    .vnu_wr_o           (vnu_wr_o),
    .iter_cnt_o         (iter_cnt_o),
    .decode_done_o      (decode_done_o),
    .overrun_o          (overrun_o)
  );

  always #5 read_clk = ~read_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Advance one clock and sample just after the edge; overrun pulses are tallied.
  task automatic tick();
    @(posedge read_clk);
    #1;
    if (overrun_o === 1'b1) ov_cnt++;
  endtask

  // One iteration: request, staggered random finish bits (plus junk on
  // disabled channels), optional early stop / busy update on the first
  // finish cycle, then an observation window for the write pulse.
  task automatic applyStimulus(input logic init, input logic [CH-1:0] en,
                               input logic [IW-1:0] mx, input logic [CH-1:0] fin,
                               input logic stop, input logic inject,
                               output logic load_seen, output logic [CH-1:0] wr_or,
                               output int pulses);
    logic [CH-1:0] remaining;
    logic [CH-1:0] sub;
    logic          first;
    int            guard;
    max_iter_i = mx;
    ch_en_i    = en;
    ov_cnt     = 0;
    iter_update_i      = 1'b1;
    vnu_init_load_en_i = init;
    tick();
    iter_update_i      = 1'b0;
    vnu_init_load_en_i = 1'b0;
    tick();
    tick();
    load_seen = init ? init_load_o : pipe_load_o;
    remaining = fin;
    first     = 1'b1;
    guard     = 0;
    wr_or     = '0;
    pulses    = 0;
    while ((remaining != '0 || first) && guard < 40) begin
      sub = (guard > 20) ? remaining : (remaining & CH'($urandom));
      vnu_rd_finish_i    = sub | (CH'($urandom) & ~en);
      early_stop_i       = first && stop;
      iter_update_i      = first && inject;
      vnu_init_load_en_i = first && inject && ($urandom_range(0, 1) == 1);
      first = 1'b0;
      tick();
      wr_or |= vnu_wr_o;
      if (vnu_wr_o != '0) pulses++;
      remaining &= ~sub;
      guard++;
    end
    vnu_rd_finish_i    = '0;
    early_stop_i       = 1'b0;
    iter_update_i      = 1'b0;
    vnu_init_load_en_i = 1'b0;
    repeat (12) begin
      tick();
      wr_or |= vnu_wr_o;
      if (vnu_wr_o != '0) pulses++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic          load_seen;
    logic [CH-1:0] wr_or;
    int            pulses;
    int            extra;
    logic          wr_seen;
    logic [CH-1:0] r_en;
    logic [CH-1:0] r_fin;
    logic [IW-1:0] r_mx;
    logic          r_stop;
    logic          r_inj;
    int            exp_iter;
    logic          exp_done;
    int            it;

    //              init  en     max    fin    stop  exp_wr p  iter   done
    vecs[0] = '{1'b1, 4'hF, 5'd3, 4'hF, 1'b0, 4'hF, 1, 5'd1, 1'b0};
    vecs[1] = '{1'b0, 4'hF, 5'd3, 4'hF, 1'b0, 4'hF, 1, 5'd2, 1'b0};
    vecs[2] = '{1'b0, 4'hF, 5'd3, 4'hF, 1'b0, 4'hF, 1, 5'd3, 1'b1};
    vecs[3] = '{1'b1, 4'h5, 5'd2, 4'h5, 1'b0, 4'h5, 1, 5'd1, 1'b0};
    vecs[4] = '{1'b0, 4'hA, 5'd2, 4'hE, 1'b0, 4'hA, 1, 5'd2, 1'b1};
    vecs[5] = '{1'b1, 4'hF, 5'd8, 4'hF, 1'b0, 4'hF, 1, 5'd1, 1'b0};
    vecs[6] = '{1'b0, 4'hF, 5'd8, 4'hF, 1'b1, 4'hF, 1, 5'd2, 1'b1};
    vecs[7] = '{1'b1, 4'h0, 5'd0, 4'h0, 1'b0, 4'h0, 0, 5'd1, 1'b1};
    vecs[8] = '{1'b1, 4'h3, 5'd1, 4'h3, 1'b0, 4'h3, 1, 5'd1, 1'b1};

    rstn               = 1'b0;
    iter_update_i      = 1'b0;
    vnu_init_load_en_i = 1'b0;
    vnu_rd_finish_i    = '0;
    ch_en_i            = '0;
    max_iter_i         = '0;
    early_stop_i       = 1'b0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_init_load", init_load_o, 0);
    checkOutput("rst_pipe_load", pipe_load_o, 0);
    checkOutput("rst_wr", vnu_wr_o, 0);
    checkOutput("rst_iter", iter_cnt_o, 0);
    checkOutput("rst_done", decode_done_o, 0);
    checkOutput("rst_overrun", overrun_o, 0);
    @(negedge read_clk);
    rstn = 1'b1;

    // Latency and staggered finish: request sampled at edge N, load visible
    // after N+2; last finish at edge M keeps load up through M+2, write at M+4.
    max_iter_i = 5'd4;
    ch_en_i    = 4'hF;
    iter_update_i      = 1'b1;
    vnu_init_load_en_i = 1'b1;
    tick();
    iter_update_i      = 1'b0;
    vnu_init_load_en_i = 1'b0;
    checkOutput("lat_n", init_load_o, 0);
    tick();
    checkOutput("lat_n1", init_load_o, 0);
    tick();
    checkOutput("lat_n2", init_load_o, 1);
    vnu_rd_finish_i = 4'h1;
    tick();
    vnu_rd_finish_i = 4'h4;
    tick();
    vnu_rd_finish_i = 4'hA;
    tick();
    vnu_rd_finish_i = 4'h0;
    checkOutput("stag_m_load", init_load_o, 1);
    tick();
    tick();
    checkOutput("stag_m2_load", init_load_o, 1);
    tick();
    checkOutput("stag_m3_load", init_load_o, 0);
    checkOutput("stag_m3_wr", vnu_wr_o, 0);
    tick();
    checkOutput("stag_m4_wr", vnu_wr_o, 4'hF);
    checkOutput("stag_m4_iter", iter_cnt_o, 1);
    tick();
    checkOutput("stag_m5_wr", vnu_wr_o, 0);
    checkOutput("stag_m5_done", decode_done_o, 0);

    // Update while in the write-wait phase is discarded with one overrun pulse.
    ov_cnt = 0;
    iter_update_i = 1'b1;
    tick();
    iter_update_i = 1'b0;
    tick();
    tick();
    checkOutput("ovr_pipe_load", pipe_load_o, 1);
    vnu_rd_finish_i = 4'hF;
    tick();
    vnu_rd_finish_i = 4'h0;
    tick();
    iter_update_i = 1'b1;
    tick();
    iter_update_i = 1'b0;
    tick();
    checkOutput("ovr_pulse", overrun_o, 1);
    tick();
    checkOutput("ovr_pulse_end", overrun_o, 0);
    checkOutput("ovr_wr", vnu_wr_o, 4'hF);
    extra = 0;
    repeat (8) begin
      tick();
      if (pipe_load_o || init_load_o) extra++;
    end
    checkOutput("ovr_no_load", extra, 0);
    checkOutput("ovr_count", ov_cnt, 1);
    checkOutput("ovr_iter", iter_cnt_o, 2);

    // Reset while waiting for the write pulse aborts the iteration.
    iter_update_i = 1'b1;
    tick();
    iter_update_i = 1'b0;
    tick();
    tick();
    vnu_rd_finish_i = 4'hF;
    tick();
    vnu_rd_finish_i = 4'h0;
    tick();
    tick();
    rstn = 1'b0;
    #1;
    checkOutput("arst_load", {init_load_o, pipe_load_o}, 0);
    checkOutput("arst_wr", vnu_wr_o, 0);
    checkOutput("arst_iter", iter_cnt_o, 0);
    checkOutput("arst_done", {decode_done_o, overrun_o}, 0);
    tick();
    tick();
    @(negedge read_clk);
    rstn = 1'b1;
    wr_seen   = 1'b0;
    load_seen = 1'b0;
    repeat (10) begin
      tick();
      if (vnu_wr_o != '0) wr_seen = 1'b1;
      if (init_load_o || pipe_load_o) load_seen = 1'b1;
    end
    checkOutput("arst_no_wr", wr_seen, 0);
    checkOutput("arst_no_load", load_seen, 0);
    checkOutput("arst_iter_after", iter_cnt_o, 0);

    // Non-init update in DONE: overrun pulse, frame stays done.
    applyStimulus(1'b1, 4'hF, 5'd1, 4'hF, 1'b0, 1'b0, load_seen, wr_or, pulses);
    checkOutput("done_setup", decode_done_o, 1);
    ov_cnt = 0;
    iter_update_i = 1'b1;
    tick();
    iter_update_i = 1'b0;
    extra = 0;
    repeat (4) begin
      tick();
      if (pipe_load_o) extra++;
    end
    checkOutput("done_ovr_count", ov_cnt, 1);
    checkOutput("done_ovr_level", decode_done_o, 1);
    checkOutput("done_ovr_no_load", extra, 0);

    // Table of iteration records
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].init, vecs[i].en, vecs[i].max_iter, vecs[i].fin,
                    vecs[i].stop, 1'b0, load_seen, wr_or, pulses);
      checkOutput($sformatf("v%0d_load", i), load_seen, 1);
      checkOutput($sformatf("v%0d_wr", i), wr_or, vecs[i].exp_wr);
      checkOutput($sformatf("v%0d_pulses", i), pulses, vecs[i].exp_pulses);
      checkOutput($sformatf("v%0d_iter", i), iter_cnt_o, vecs[i].exp_iter);
      checkOutput($sformatf("v%0d_done", i), decode_done_o, vecs[i].exp_done);
      checkOutput($sformatf("v%0d_ovr", i), ov_cnt, 0);
    end

    // Random frames against the iteration-level model
    for (int f = 0; f < 8; f++) begin
      r_mx     = IW'($urandom_range(0, 4));
      exp_iter = 0;
      exp_done = 1'b0;
      it       = 0;
      while (!exp_done && it < 6) begin
        r_en   = CH'($urandom);
        r_fin  = r_en | CH'($urandom);
        r_stop = ($urandom_range(0, 5) == 0);
        r_inj  = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 3) == 0) begin
          early_stop_i = 1'b1;
          tick();
          early_stop_i = 1'b0;
          tick();
        end
        applyStimulus(it == 0, r_en, r_mx, r_fin, r_stop, r_inj, load_seen, wr_or, pulses);
        exp_iter++;
        exp_done = (exp_iter >= ((r_mx == '0) ? 1 : int'(r_mx))) || r_stop;
        checkOutput($sformatf("r%0d_%0d_load", f, it), load_seen, 1);
        checkOutput($sformatf("r%0d_%0d_wr", f, it), wr_or, r_en);
        checkOutput($sformatf("r%0d_%0d_pulses", f, it), pulses, (r_en != '0) ? 1 : 0);
        checkOutput($sformatf("r%0d_%0d_iter", f, it), iter_cnt_o, exp_iter);
        checkOutput($sformatf("r%0d_%0d_done", f, it), decode_done_o, exp_done);
        checkOutput($sformatf("r%0d_%0d_ovr", f, it), ov_cnt, r_inj ? 1 : 0);
        it++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/vnu_wr_update_ctrl.md
VNU_WR_UPDATE_CTRL -- requirements
Module: vnu_wr_update_ctrl

Interface
REQ-001 Parameter CH_NUM, default 4: number of VNU channels handshaked in parallel (1..16).
REQ-002 Parameter WR_LAT, default 2: cycles from load-complete to write pulse (1..15).
REQ-003 Parameter ITER_W, default 5: iteration counter width.
REQ-004 read_clk  input  1  sole clock; all logic on rising edge; one clock and no CDC inside the block.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 iter_update_i  input  1  iteration-update request.
REQ-007 vnu_init_load_en_i  input  1  request is the initial-load (first iteration of a frame).
REQ-008 vnu_rd_finish_i  input  CH_NUM  per-channel read-finish strobe for the current iteration.
REQ-009 ch_en_i  input  CH_NUM  channel enable mask; sampled on leaving IDLE/DONE.
REQ-010 max_iter_i  input  ITER_W  iteration limit per frame; value 0 is treated as 1.
REQ-011 early_stop_i  input  1  syndrome-pass stop request.
REQ-012 init_load_o  output  1  initial-load phase active.
REQ-013 pipe_load_o  output  1  pipeline-load phase active.
REQ-014 vnu_wr_o  output  CH_NUM  one-cycle write pulse per enabled channel.
REQ-015 iter_cnt_o  output  ITER_W  completed iterations in current frame.
REQ-016 decode_done_o  output  1  frame finished; level.
REQ-017 overrun_o  output  1  one-cycle pulse: iter_update_i ignored while busy.

Function
REQ-018 iter_update_i, vnu_init_load_en_i, vnu_rd_finish_i and early_stop_i SHALL be registered once before use; all outputs SHALL be registered (Moore).
REQ-019 States SHALL be IDLE, INIT_LOAD, PIPE_LOAD, WR_WAIT, WR_PULSE, DONE.
REQ-020 IDLE: registered update with init-load-en -> INIT_LOAD and iter_cnt cleared; update without init-load-en -> PIPE_LOAD.
REQ-021 On entry to either load state the block SHALL latch ch_en_i and clear the sticky finish mask.
REQ-022 In load states, sticky mask |= registered finish bits; disabled-channel bits ignored.
REQ-023 When (mask | ~ch_en_latched) is all-ones, -> WR_WAIT if WR_LAT>1, else WR_PULSE; empty ch_en -> completes first load cycle.
REQ-024 init_load_o / pipe_load_o SHALL be high exactly while in INIT_LOAD / PIPE_LOAD.
REQ-025 WR_WAIT SHALL last WR_LAT-1 cycles via down-counter, then -> WR_PULSE.
REQ-026 WR_PULSE: vnu_wr_o = ch_en_latched for one cycle; iter_cnt increments with saturation at all-ones.
REQ-027 After WR_PULSE: -> DONE if new iter_cnt >= max(max_iter_i,1) or early-stop flag set; else -> IDLE.
REQ-028 early_stop_i seen registered at any non-IDLE/DONE state SHALL set a flag consumed at WR_PULSE; current iteration completes.
REQ-029 DONE: decode_done_o=1; registered update with init-load-en -> INIT_LOAD (new frame, counter cleared, done dropped); update without it -> overrun_o pulse, stay.
REQ-030 Registered update seen in any state other than IDLE/DONE SHALL pulse overrun_o and be discarded.
REQ-031 Latency: iter_update_i high at edge N -> load output high after edge N+2.

Reset
REQ-032 rstn low SHALL force IDLE, all outputs 0, iter_cnt 0, mask/flags/counter 0, input registers 0, regardless of state.
REQ-033 Reset mid-operation SHALL abort without any vnu_wr_o pulse; first release edge only samples inputs.

Structure
REQ-034 Package vnu_ctrl_pkg SHALL hold the state enum, WR_LAT counter width function and default parameter constants.
REQ-035 Sub-module vnu_finish_collector (sticky mask plus all-done compare) SHALL be the only child instance.

Verification
REQ-036 CH_NUM=4, en=1111, init update, finish bits staggered 0001,0100,1010 -> init_load_o 3 cycles after last bit, vnu_wr_o=1111 after 2 more cycles, iter_cnt_o=1.
REQ-037 max_iter=3: init then two pipe updates -> pipe_load_o twice, third write pulse followed by decode_done_o=1, iter_cnt_o=3.
REQ-038 en=0101, only bits 0,2 finish -> vnu_wr_o=0101; bits 1,3 never needed.
REQ-039 iter_update_i pulsed during WR_WAIT -> overrun_o one pulse, no extra load phase.
REQ-040 early_stop_i during PIPE_LOAD at iteration 1 of max 8 -> write completes, DONE with iter_cnt_o=2.
REQ-041 rstn low during WR_WAIT -> all outputs 0 immediately, no vnu_wr_o pulse after release.
